// File: rtl/irq_controller_pkg.sv
// Shared types and default bus addresses for the interrupt controller slice.
package irq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_REQ,
    ST_ACK,
    ST_GUARD
  } irq_state_t;

  localparam logic [7:0] IRQ_PEND_ADDR = 8'hF0;
  localparam logic [7:0] IRQ_MASK_ADDR = 8'hF1;

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side interrupt handshake: request, source id and acknowledge.
interface irq_controller_if #(
  parameter int ID_W = 3
);
  logic            INT_REQ;
  logic [ID_W-1:0] INT_ID;
  logic            INT_ACK;

  modport master (output INT_REQ, output INT_ID, input INT_ACK);
  modport slave  (input INT_REQ, input INT_ID, output INT_ACK);
endinterface

// File: rtl/irq_priority_enc.sv
// Combinational lowest-index-first priority encoder.
module irq_priority_enc #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan from the top so the lowest set index is written last.
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (req[NUM_IRQ-1-i]) idx = ID_W'(NUM_IRQ-1-i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller with bus-readable pending register.
// Define IRQ_MASK_EN to add the writable mask register at BASE_ADDR+1.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int         NUM_IRQ   = 4,
  parameter int         ID_W      = 3,
  parameter logic [7:0] BASE_ADDR = IRQ_PEND_ADDR
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] IRQ_IN,
  output logic [NUM_IRQ-1:0] IRQ_ACK_OUT,
  irq_controller_if.master   cpu,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE
);

  localparam logic [7:0] MASK_ADDR = BASE_ADDR + 8'd1;

  irq_state_t         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] ack_vec;
  logic [ID_W-1:0]    int_id;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_idx;
  logic               rd_en;
  logic [7:0]         rd_data;

  irq_priority_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_enc (
    .req   (pending & mask),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

`ifdef IRQ_MASK_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                              mask <= '1;
    else if (BUS_WE && BUS_ADDR == MASK_ADDR) mask <= BUS_DATA[NUM_IRQ-1:0];
  end
`else
  assign mask = '1;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      irq_d   <= '0;
      pending <= '0;
      int_id  <= '0;
    end else begin
      state_q <= state_d;
      irq_d   <= IRQ_IN;
      // A fresh edge on the bit being cleared keeps it pending.
      pending <= (pending & ~ack_vec) | (IRQ_IN & ~irq_d);
      if (state_q == ST_ARB && enc_valid) int_id <= enc_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_vec     = '0;
    cpu.INT_REQ = 1'b0;
    cpu.INT_ID  = int_id;
    case (state_q)
      ST_IDLE:  if (enc_valid) state_d = ST_ARB;
      ST_ARB:   state_d = enc_valid ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        cpu.INT_REQ = 1'b1;
        if (cpu.INT_ACK) state_d = ST_ACK;
      end
      ST_ACK: begin
        ack_vec = NUM_IRQ'(1) << int_id;
        state_d = ST_GUARD;
      end
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    IRQ_ACK_OUT = ack_vec;
  end

  // Read data is registered from the address seen at the edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_en   <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_en   <= 1'b0;
      rd_data <= '0;
      if (!BUS_WE && BUS_ADDR == BASE_ADDR) begin
        rd_en   <= 1'b1;
        rd_data <= 8'(pending);
      end
`ifdef IRQ_MASK_EN
      else if (!BUS_WE && BUS_ADDR == MASK_ADDR) begin
        rd_en   <= 1'b1;
        rd_data <= 8'(mask);
      end
`endif
    end
  end

  assign BUS_DATA = rd_en ? rd_data : 8'hzz;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed test-plan steps plus randomized bursts.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  wire  [3:0] irq_ack;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic       drv_en;
  logic [7:0] drv_val;
  wire  [7:0] bus_data;
  int         tests = 0;
  int         fails = 0;

  always #10 clk = ~clk;

  irq_controller_if #(.ID_W(3)) cpu ();

  irq_controller #(
    .NUM_IRQ   (4),
    .ID_W      (3),
    .BASE_ADDR (8'hF0)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .IRQ_IN      (irq_in),
    .IRQ_ACK_OUT (irq_ack),
    .cpu         (cpu.master),
    .BUS_DATA    (bus_data),
    .BUS_ADDR    (bus_addr),
    .BUS_WE      (bus_we)
  );

  assign bus_data = drv_en ? drv_val : 8'hzz;
  // Undriven bus floats high, so a released bus reads 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus_data[g]);
  end

  localparam logic [7:0] BUS_Z = 8'hFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: index of the lowest set bit via two's-complement isolation.
  function automatic int lowest(input logic [3:0] v);
    logic [3:0] iso;
    iso = v & (~v + 4'd1);
    return $clog2(iso);
  endfunction

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    bus_addr = a;
    bus_we   = 1'b0;
    drv_en   = 1'b0;
    tick();
    d = bus_data;
    bus_addr = 8'h00;
    tick();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a;
    drv_val  = d;
    drv_en   = 1'b1;
    bus_we   = 1'b1;
    tick();
    bus_we   = 1'b0;
    drv_en   = 1'b0;
    bus_addr = 8'h00;
  endtask

  // CPU plus peripheral model: take one request, ack it, drop the acked source line.
  task automatic serve(input int exp_id, input int hold);
    int         n = 0;
    int         pulses = 0;
    logic [3:0] seen = '0;
    while (!cpu.INT_REQ && n < 30) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(cpu.INT_REQ), 1);
    chk("int_id", 32'(cpu.INT_ID), 32'(exp_id));
    cpu.INT_ACK = 1'b1;
    for (int c = 0; c < hold + 3; c++) begin
      tick();
      if (c == hold - 1) cpu.INT_ACK = 1'b0;
      if (irq_ack != 4'b0) begin
        pulses++;
        seen   |= irq_ack;
        irq_in &= ~irq_ack;
      end
    end
    chk("ack_pulses", 32'(pulses), 1);
    chk("ack_onehot", 32'(seen), 32'(4'b1 << exp_id));
    if (hold == 1) chk("no_early_req", 32'(cpu.INT_REQ), 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic [3:0] r, m, rest;
    int         n;
    int         hold;

    rst = 1'b1; irq_in = '0; cpu.INT_ACK = 1'b0;
    bus_addr = 8'h00; bus_we = 1'b0; drv_en = 1'b0; drv_val = '0;
    tick(); tick();
    chk("rst_int_req", 32'(cpu.INT_REQ), 0);
    chk("rst_int_id", 32'(cpu.INT_ID), 0);
    chk("rst_ack", 32'(irq_ack), 0);
    chk("rst_bus_z", 32'(bus_data), 32'(BUS_Z));
    rst = 1'b0;
    read_reg(8'hF0, rd); chk("rst_pend", 32'(rd), 0);
`ifdef IRQ_MASK_EN
    read_reg(8'hF1, rd); chk("rst_mask", 32'(rd), 32'h0F);
`else
    read_reg(8'hF1, rd); chk("mask_undecoded", 32'(rd), 32'(BUS_Z));
`endif

    // Single source: request two cycles after the first sample.
    irq_in = 4'b0010;
    tick(); chk("lat_k", 32'(cpu.INT_REQ), 0);
    tick(); chk("lat_k1", 32'(cpu.INT_REQ), 0);
    tick(); chk("lat_k2", 32'(cpu.INT_REQ), 1);
    chk("lat_id", 32'(cpu.INT_ID), 1);
    tick(); tick();
    serve(1, 1);
    read_reg(8'hF0, rd); chk("single_pend", 32'(rd), 0);

    // Simultaneous sources served lowest first.
    irq_in = 4'b1010;
    serve(1, 1);
    serve(3, 1);
    read_reg(8'hF0, rd); chk("simul_pend", 32'(rd), 0);

`ifdef IRQ_MASK_EN
    write_reg(8'hF1, 8'hFE);
    irq_in = 4'b0001;
    repeat (6) tick();
    chk("masked_no_req", 32'(cpu.INT_REQ), 0);
    read_reg(8'hF0, rd); chk("masked_pend", 32'(rd), 32'h01);
    read_reg(8'hF1, rd); chk("mask_rd", 32'(rd), 32'h0E);
    write_reg(8'hF1, 8'h0F);
    serve(0, 1);
`else
    write_reg(8'hF1, 8'h00);
    irq_in = 4'b0001;
    serve(0, 1);
`endif
    write_reg(8'hF0, 8'h0F);
    read_reg(8'hF0, rd); chk("pend_ro", 32'(rd), 0);

    // Long CPU acknowledge yields one ack; the next request is unaffected.
    irq_in = 4'b0100;
    serve(2, 10);
    irq_in = 4'b0010;
    serve(1, 1);

    // Reset in the middle of a request.
`ifdef IRQ_MASK_EN
    write_reg(8'hF1, 8'h0C);
`endif
    irq_in = 4'b1000;
    n = 0;
    while (!cpu.INT_REQ && n < 30) begin tick(); n++; end
    chk("pre_rst_req", 32'(cpu.INT_REQ), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(cpu.INT_REQ), 0);
    chk("async_rst_ack", 32'(irq_ack), 0);
    irq_in = 4'b0000;
    tick();
    rst = 1'b0;
    read_reg(8'hF0, rd); chk("post_rst_pend", 32'(rd), 0);
`ifdef IRQ_MASK_EN
    read_reg(8'hF1, rd); chk("post_rst_mask", 32'(rd), 32'h0F);
`endif
    repeat (4) tick();
    chk("post_rst_idle", 32'(cpu.INT_REQ), 0);
    irq_in = 4'b0100;
    serve(2, 1);

    // Read timing: data one cycle after the address, otherwise released.
    irq_in = 4'b0100;
    tick(); tick();
    bus_addr = 8'hF0;
    chk("rd_before_edge", 32'(bus_data), 32'(BUS_Z));
    tick();
    chk("rd_after_edge", 32'(bus_data), 32'h04);
    bus_addr = 8'h55;
    tick();
    chk("rd_other_addr", 32'(bus_data), 32'(BUS_Z));
    bus_addr = 8'h00;
    serve(2, 1);

    // Randomized bursts against the reference order.
    for (int it = 0; it < 20; it++) begin
      r = 4'($urandom_range(1, 15));
`ifdef IRQ_MASK_EN
      m = 4'($urandom_range(0, 15));
      write_reg(8'hF1, 8'(m));
`else
      m = 4'hF;
`endif
      irq_in = r;
      rest = r & m;
      while (rest != 4'b0) begin
        hold = $urandom_range(1, 3);
        serve(lowest(rest), hold);
        rest &= rest - 4'd1;
      end
      repeat (3) tick();
      chk("rnd_idle", 32'(cpu.INT_REQ), 0);
      read_reg(8'hF0, rd); chk("rnd_pend_left", 32'(rd), 32'(r & ~m));
`ifdef IRQ_MASK_EN
      write_reg(8'hF1, 8'h0F);
      rest = r & ~m;
      while (rest != 4'b0) begin
        serve(lowest(rest), 1);
        rest &= rest - 4'd1;
      end
      read_reg(8'hF0, rd); chk("rnd_pend_drained", 32'(rd), 0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Bus-mapped interrupt controller that collects level requests from the peripherals (switches, mouse, timer, …), arbitrates them by fixed priority and presents one interrupt at a time to the CPU. It sits directly downstream of each peripheral's `SEND_INTERRUPT` output and returns the per-source `INTERRUPT_ACK` pulse. Pending status and an optional mask register are exposed on the 8-bit data bus at base 0xF0.

## Interface
- `NUM_IRQ`, 4: number of interrupt sources; legal range 1–8.
- `ID_W`, 3: width of `INT_ID`; must satisfy 2^ID_W ≥ NUM_IRQ.
- `BASE_ADDR`, 8'hF0: bus address of the pending register; mask register is at BASE_ADDR+1.

Ports:
- `CLK` in 1: system clock, 50 MHz.
- `RESET` in 1: asynchronous, active-high reset.
- `IRQ_IN` in NUM_IRQ: peripheral `SEND_INTERRUPT` lines, synchronous to CLK, held high until acked.
- `IRQ_ACK_OUT` out NUM_IRQ: one-hot, one-cycle ack to the winning source's `INTERRUPT_ACK`.
- `INT_REQ` out 1: interrupt request to the CPU.
- `INT_ID` out ID_W: index of the requesting source, valid while INT_REQ=1.
- `INT_ACK` in 1: CPU acknowledge.
- `BUS_DATA` inout 8: shared data bus.
- `BUS_ADDR` in 8: bus address.
- `BUS_WE` in 1: bus write enable.

## Operation
- Edge capture: `irq_d <= IRQ_IN`. When `IRQ_IN[i] & ~irq_d[i]`, `pending[i]` is set. Levels held high do not re-set pending after clear.
- Clear: `pending[id]` is cleared in the ACK state. If a new rising edge on the same bit coincides with the clear, the set wins.
- Arbitration: the candidate set is `pending & mask`. The lowest index wins.
- FSM states:
  - IDLE: go to ARB if any candidate.
  - ARB: latch the winner into `INT_ID`, then go to REQ.
  - REQ: `INT_REQ`=1; hold until `INT_ACK`=1, then go to ACK.
  - ACK: `IRQ_ACK_OUT[INT_ID]`=1 for this cycle only; clear pending; then go to GUARD.
  - GUARD: one idle cycle so the source drops its line; then go to IDLE.
- `INT_ACK` outside REQ is ignored. `INT_ACK` held high for multiple cycles produces exactly one ACK.
- A mask change during REQ does not withdraw the in-flight request.
- Bus read (BUS_WE=0):
  - At BASE_ADDR, the read returns `pending` zero-extended.
  - At BASE_ADDR+1, the read returns `mask` zero-extended.
  - Bits ≥ NUM_IRQ read 0.
- Bus write (BUS_WE=1): at BASE_ADDR+1, `mask <= BUS_DATA[NUM_IRQ-1:0]`. Writes to BASE_ADDR are ignored. Pending is read-only.
- Reset values:
  - `INT_REQ`=0, `INT_ID`=0, `IRQ_ACK_OUT`=0.
  - `pending`=0, `irq_d`=0, `mask`=all ones.
  - FSM=IDLE; BUS_DATA tri-stated.
- Reset mid-handshake aborts everything immediately. The source stays unacked and re-raises via a new edge.

## Timing
- `IRQ_IN[i]` first sampled high at edge k: pending set at k, ARB at k+1, `INT_REQ` high after edge k+2.
- `INT_ACK` sampled high at edge m: `INT_REQ` low and `IRQ_ACK_OUT` high after m. Ack low after m+1. Next ARB no earlier than m+3.
- Bus read: one cycle registered latency. The enable and data are registered from address/WE at edge n and driven after n. The bus is otherwise Z.
- Bus write takes effect at the sampling edge. A read of the mask in the following cycle returns the new value.

## Configuration
- `IRQ_MASK_EN` defined: the mask register exists as described above.
- `IRQ_MASK_EN` undefined:
  - The mask is the constant all ones.
  - BASE_ADDR+1 is not decoded; reads leave the bus Z and writes are ignored.
  - Only the pending register is readable.

## Structure
- Package `irq_ctrl_pkg` holds:
  - The FSM state enum (IDLE, ARB, REQ, ACK, GUARD).
  - Default address constants `IRQ_PEND_ADDR`=8'hF0 and `IRQ_MASK_ADDR`=8'hF1.
- Sub-module `irq_priority_enc`: combinational lowest-index-first encoder. It takes a NUM_IRQ-bit vector and outputs `valid` and `idx[ID_W-1:0]`.

## Test plan
- Single source: raise IRQ_IN=4'b0010, then pulse INT_ACK at cycle 5.
  - Expect INT_REQ=1 with INT_ID=1 two cycles after the first sample.
  - Expect IRQ_ACK_OUT=4'b0010 for exactly one cycle.
  - Expect pending reads 0x00.
- Simultaneous IRQ_IN=4'b1010:
  - First INT_ID=1 and only it is acked.
  - Second INT_ID=3 follows after GUARD.
  - Exactly two ack pulses in total.
- Mask (IRQ_MASK_EN): write 0xFE to 0xF1, raise IRQ_IN[0].
  - INT_REQ stays 0 and reading 0xF0 returns 0x01.
  - Write 0x0F to 0xF1: INT_REQ with INT_ID=0 follows.
- INT_ACK held high for 10 cycles in REQ → one IRQ_ACK_OUT pulse only. Next request is unaffected.
- Assert RESET during REQ → INT_REQ, pending and IRQ_ACK_OUT are 0 immediately and mask reads 0x0F. A re-raised IRQ_IN[2] is served normally.
- Bus read of 0xF0 with BUS_WE=0 at edge n → BUS_DATA valid after n. With BUS_ADDR=0x55 → BUS_DATA remains Z.
